// File: rtl/z88_pkg.sv
// Shared types and constants for the Z88 RAM arbitration path.
package z88_pkg;

  localparam int unsigned RAM_AW = 19;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } seq_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LCD
  } owner_t;

endpackage

// File: rtl/z88_ram_strobe_seq.sv
// RAM access sequencer: IDLE -> SETUP -> STROBE x N -> HOLD, with registered pin drivers.
module z88_ram_strobe_seq
  import z88_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [RAM_AW-1:0] start_a,
  input  logic [7:0]        start_wdata,
  output logic              idle,
  output logic              sample,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_do,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [3:0] LastCnt = 4'(STROBE_CYCLES - 1);

  seq_state_t state_q;
  logic [3:0] cnt_q;
  logic       wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      ram_a    <= '0;
      ram_do   <= 8'h00;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SETUP;
            ram_a    <= start_a;
            wr_q     <= start_we;
            ram_ce_n <= 1'b0;
            if (start_we) ram_do <= start_wdata;
          end
        end
        SETUP: begin
          state_q  <= STROBE;
          cnt_q    <= 4'd0;
          ram_oe_n <= wr_q;
          ram_we_n <= ~wr_q;
        end
        STROBE: begin
          if (cnt_q == LastCnt) begin
            state_q  <= HOLD;
            cnt_q    <= 4'd0;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HOLD: begin
          state_q  <= IDLE;
          ram_ce_n <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle   = (state_q == IDLE);
  // Asserted for the final STROBE cycle; the edge ending it captures read data.
  assign sample = (state_q == STROBE) && (cnt_q == LastCnt);

endmodule

// File: rtl/z88_ram_arbiter.sv
// Shares the external SRAM between the Z80 memory path and the LCD fetch engine,
// with an ageing counter that bounds LCD fetch latency.
module z88_ram_arbiter
  import z88_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned LCD_MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_a,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              lcd_req,
  input  logic [RAM_AW-1:0] lcd_a,
  output logic [7:0]        lcd_rdata,
  output logic              lcd_ack,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_do,
  input  logic [7:0]        ram_di,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [7:0] MaxWait = 8'(LCD_MAX_WAIT);

  logic       idle, sample, start, grant_lcd, lcd_busy;
  owner_t     owner_q;
  logic       wr_q;
  logic [7:0] lcd_age_q;
  logic [7:0] cpu_rdata_q, lcd_rdata_q;
  logic       cpu_ack_q, lcd_ack_q;

  // An aged LCD request overrides the CPU's normal priority.
  assign grant_lcd = lcd_req && ((lcd_age_q >= MaxWait) || !cpu_req);
  assign start     = idle && (cpu_req || lcd_req);
  assign lcd_busy  = !idle && (owner_q == OWN_LCD);

  z88_ram_strobe_seq #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_we    (grant_lcd ? 1'b0 : cpu_we),
    .start_a     (grant_lcd ? lcd_a : cpu_a),
    .start_wdata (cpu_wdata),
    .idle        (idle),
    .sample      (sample),
    .ram_a       (ram_a),
    .ram_do      (ram_do),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      wr_q        <= 1'b0;
      lcd_age_q   <= 8'd0;
      cpu_rdata_q <= 8'h00;
      lcd_rdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      lcd_ack_q   <= 1'b0;
    end else begin
      cpu_ack_q <= sample && (owner_q == OWN_CPU);
      lcd_ack_q <= sample && (owner_q == OWN_LCD);
      if (start) begin
        owner_q <= grant_lcd ? OWN_LCD : OWN_CPU;
        wr_q    <= !grant_lcd && cpu_we;
      end
      if (sample && !wr_q) begin
        if (owner_q == OWN_LCD) lcd_rdata_q <= ram_di;
        else                    cpu_rdata_q <= ram_di;
      end
      if (!lcd_req || (start && grant_lcd)) begin
        lcd_age_q <= 8'd0;
      end else if (!lcd_busy && (lcd_age_q != 8'hFF)) begin
        lcd_age_q <= lcd_age_q + 8'd1;
      end
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign lcd_rdata  = lcd_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign lcd_ack    = lcd_ack_q;
  assign cpu_wait_n = !(cpu_req && !cpu_ack_q);

endmodule

// File: tb/tb_z88_ram_arbiter.sv
// Scoreboarded bench for z88_ram_arbiter: directed timing cases plus randomized traffic.
module tb_z88_ram_arbiter;

  localparam int unsigned SC     = 2;
  localparam int unsigned MW     = 8;
  localparam int unsigned PERIOD = SC + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, mem_clr;
  logic        cpu_req, cpu_we, cpu_ack, cpu_wait_n;
  logic [18:0] cpu_a, lcd_a, ram_a;
  logic [7:0]  cpu_wdata, cpu_rdata, lcd_rdata, ram_do, ram_di;
  logic        lcd_req, lcd_ack, ram_ce_n, ram_oe_n, ram_we_n;

  z88_ram_arbiter #(.STROBE_CYCLES(SC), .LCD_MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .lcd_req(lcd_req), .lcd_a(lcd_a), .lcd_rdata(lcd_rdata), .lcd_ack(lcd_ack),
    .ram_a(ram_a), .ram_do(ram_do), .ram_di(ram_di),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // Second instance with single-cycle strobes, LCD reads only.
  logic        lcd2_req, lcd2_ack, cpu2_ack, cpu2_wait_n, ce2_n, oe2_n, we2_n;
  logic [18:0] lcd2_a, ram2_a;
  logic [7:0]  lcd2_rdata, cpu2_rdata, ram2_do, ram2_di;

  z88_ram_arbiter #(.STROBE_CYCLES(1), .LCD_MAX_WAIT(MW)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_a(19'h0), .cpu_wdata(8'h00),
    .cpu_rdata(cpu2_rdata), .cpu_ack(cpu2_ack), .cpu_wait_n(cpu2_wait_n),
    .lcd_req(lcd2_req), .lcd_a(lcd2_a), .lcd_rdata(lcd2_rdata), .lcd_ack(lcd2_ack),
    .ram_a(ram2_a), .ram_do(ram2_do), .ram_di(ram2_di),
    .ram_ce_n(ce2_n), .ram_oe_n(oe2_n), .ram_we_n(we2_n)
  );

  function automatic logic [7:0] f(input logic [18:0] a);
    if (a == 19'h12345) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  // SRAM: fixed pattern everywhere, writable page at 0x7FF00..0x7FFFF.
  logic [7:0] phys_hi [0:255];
  logic       wr_v    [0:255];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) wr_v[i] <= 1'b0;
    end else if (!ram_ce_n && !ram_we_n && ram_a[18:8] == 11'h7FF) begin
      phys_hi[ram_a[7:0]] <= ram_do;
      wr_v[ram_a[7:0]]    <= 1'b1;
    end
  end
  always_comb begin
    ram_di = f(ram_a);
    if (ram_a[18:8] == 11'h7FF && wr_v[ram_a[7:0]]) ram_di = phys_hi[ram_a[7:0]];
  end
  assign ram2_di = f(ram2_a);

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as seen by requesters, plus expected-response queues.
  logic [7:0] ref_wr [int];
  logic [8:0] cpu_q [$];
  logic [7:0] lcd_q [$];

  function automatic logic [7:0] model_read(input logic [18:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return f(a);
  endfunction

  task automatic cpu_start(input logic we, input logic [18:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_wdata = d;
    if (we) begin
      ref_wr[int'(a)] = d;
      cpu_q.push_back({1'b0, 8'h00});
    end else begin
      cpu_q.push_back({1'b1, model_read(a)});
    end
  endtask

  task automatic lcd_start(input logic [18:0] a);
    lcd_req = 1'b1; lcd_a = a;
    lcd_q.push_back(f(a));
  endtask

  task automatic cpu_wait_ack(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cpu_ack) begin at = cyc; break; end
      check("cpu_wait_n_low", cpu_wait_n, 1'b0);
    end
    if (at < 0) check("cpu_ack_timeout", 0, 1);
  endtask

  task automatic lcd_wait_ack(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lcd_ack) begin at = cyc; break; end
    end
    if (at < 0) check("lcd_ack_timeout", 0, 1);
  endtask

  // Scoreboard monitor: pop and compare on every ack.
  always @(negedge clk) begin
    logic [8:0] ce;
    if (cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_ack_unexpected", 1, 0);
      else begin
        ce = cpu_q.pop_front();
        if (ce[8]) check("cpu_rdata", cpu_rdata, ce[7:0]);
      end
    end
    if (lcd_ack) begin
      if (lcd_q.size() == 0) check("lcd_ack_unexpected", 1, 0);
      else check("lcd_rdata", lcd_rdata, lcd_q.pop_front());
    end
  end

  // Pin protocol monitor over each ce_n-low window.
  int          pos = 0;
  logic [18:0] run_a;
  logic [7:0]  run_do;
  logic        run_rd;
  always @(negedge clk) begin
    if (reset) begin
      pos <= 0;
    end else if (!ram_ce_n) begin
      if (pos == 0) begin
        run_a <= ram_a; run_do <= ram_do;
      end else begin
        check("ram_a_stable", ram_a, run_a);
        check("ram_do_stable", ram_do, run_do);
      end
      if (pos >= 1 && pos <= int'(SC)) begin
        check("one_strobe_low", ({ram_oe_n, ram_we_n} == 2'b01) || ({ram_oe_n, ram_we_n} == 2'b10), 1);
        if (pos == 1) run_rd <= !ram_oe_n;
        else check("strobe_dir_const", !ram_oe_n, run_rd);
      end else begin
        check("strobes_high_setup_hold", {ram_oe_n, ram_we_n}, 2'b11);
      end
      pos <= pos + 1;
    end else if (pos != 0) begin
      check("ce_low_len", pos, SC + 2);
      pos <= 0;
    end
  end

  initial begin
    int t0, tc, tl, t1, t2;
    int ta [3];
    reset = 1'b1; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_wdata = '0;
    lcd_req = 1'b0; lcd_a = '0; lcd2_req = 1'b0; lcd2_a = '0;
    repeat (3) @(negedge clk);
    check("rst_ce_n", ram_ce_n, 1); check("rst_oe_n", ram_oe_n, 1); check("rst_we_n", ram_we_n, 1);
    check("rst_ram_a", ram_a, 0); check("rst_ram_do", ram_do, 0);
    check("rst_acks", {cpu_ack, lcd_ack}, 0);
    check("rst_rdata", {cpu_rdata, lcd_rdata}, 0);
    check("rst_wait_n", cpu_wait_n, 1);
    reset = 1'b0; mem_clr = 1'b0;
    repeat (2) @(negedge clk);

    // CPU read with 0x5A at 0x12345
    t0 = cyc; cpu_start(1'b0, 19'h12345, 8'h00);
    #1 check("wait_n_on_req", cpu_wait_n, 0);
    cpu_wait_ack(tc);
    check("cpu_rd_latency", tc - t0, SC + 2);
    check("cpu_rd_5a", cpu_rdata, 8'h5A);
    check("wait_n_on_ack", cpu_wait_n, 1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // CPU write 0xC3 to 0x7FFFF, then read it back
    t0 = cyc; cpu_start(1'b1, 19'h7FFFF, 8'hC3);
    cpu_wait_ack(tc);
    check("cpu_wr_latency", tc - t0, SC + 2);
    check("wr_ram_a", ram_a, 19'h7FFFF); check("wr_ram_do", ram_do, 8'hC3);
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_start(1'b0, 19'h7FFFF, 8'h00); cpu_wait_ack(tc); cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous requests with a young LCD request: CPU first, LCD next access
    t0 = cyc; cpu_start(1'b0, 19'h00100, 8'h00); lcd_start(19'h00200);
    fork
      begin cpu_wait_ack(tc); cpu_req = 1'b0; end
      begin lcd_wait_ack(tl); lcd_req = 1'b0; end
    join
    check("simul_cpu_ack", tc - t0, SC + 2);
    check("simul_lcd_ack", tl - t0, PERIOD + SC + 2);
    repeat (2) @(negedge clk);

    // CPU back-to-back while LCD waits: LCD takes the first IDLE with age >= MW
    t0 = cyc;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          cpu_start(1'b0, 19'h00400 + 19'(k), 8'h00);
          cpu_wait_ack(ta[k]);
        end
        cpu_req = 1'b0;
      end
      begin lcd_start(19'h00500); lcd_wait_ack(tl); lcd_req = 1'b0; end
    join
    begin
      int kl;
      kl = (MW + PERIOD - 1) / PERIOD;
      check("aged_lcd_ack", tl - t0, kl * PERIOD + SC + 2);
      check("aged_cpu_ack0", ta[0] - t0, SC + 2);
      check("aged_cpu_ack1", ta[1] - t0, PERIOD + SC + 2);
      check("aged_cpu_resume", ta[2] - t0, (kl + 1) * PERIOD + SC + 2);
    end
    repeat (2) @(negedge clk);

    // Reset during the STROBE phase of a write, with an LCD request ageing
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 19'h7FFE0; cpu_wdata = 8'h11;
    @(negedge clk);
    lcd_start(19'h00300);
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("abort_ce_n", ram_ce_n, 1); check("abort_we_n", ram_we_n, 1);
    check("abort_no_ack", cpu_ack, 0);
    check("abort_lcd_age", dut.lcd_age_q, 0);
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc; cpu_start(1'b0, 19'h7FFFF, 8'h00);
    fork
      begin cpu_wait_ack(tc); cpu_req = 1'b0; end
      begin lcd_wait_ack(tl); lcd_req = 1'b0; end
    join
    check("post_reset_cpu", tc - t0, SC + 2);
    check("post_reset_lcd", tl - t0, PERIOD + SC + 2);
    repeat (2) @(negedge clk);

    // Randomized concurrent traffic
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int gap, tk;
          logic we;
          logic [18:0] a;
          gap = $urandom_range(0, 3);
          we  = 1'($urandom_range(0, 1));
          if (we || $urandom_range(0, 1) == 1) a = 19'h7FFF0 + 19'($urandom_range(0, 15));
          else a = 19'($urandom % 32'h40000);
          cpu_start(we, a, 8'($urandom));
          cpu_wait_ack(tk);
          if (gap != 0) begin cpu_req = 1'b0; repeat (gap) @(negedge clk); end
        end
        cpu_req = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          int gap, ts, tk;
          gap = $urandom_range(0, 3);
          ts = cyc;
          lcd_start(19'($urandom % 32'h40000));
          lcd_wait_ack(tk);
          check("lcd_latency_bound", (tk - ts) <= int'(MW + 2 * PERIOD), 1);
          if (gap != 0) begin lcd_req = 1'b0; repeat (gap) @(negedge clk); end
        end
        lcd_req = 1'b0;
      end
    join

    // Single-cycle strobes: back-to-back LCD reads at 0x00000/0x00001
    repeat (2) @(negedge clk);
    t0 = cyc; lcd2_req = 1'b1; lcd2_a = 19'h00000;
    t1 = -1;
    for (int n = 0; n < 50 && t1 < 0; n++) begin @(negedge clk); if (lcd2_ack) t1 = cyc; end
    check("sc1_ack_latency", t1 - t0, 3);
    check("sc1_rdata0", lcd2_rdata, f(19'h00000));
    lcd2_a = 19'h00001;
    t2 = -1;
    for (int n = 0; n < 50 && t2 < 0; n++) begin @(negedge clk); if (lcd2_ack) t2 = cyc; end
    check("sc1_period", t2 - t1, 4);
    check("sc1_rdata1", lcd2_rdata, f(19'h00001));
    lcd2_req = 1'b0;

    repeat (4) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("lcd_q_drained", lcd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
